perf_counter_sequencer: RTL and testbench



---
 rtl/perf_seq_pkg.sv | 52 +++++
 rtl/perf_seq_rr_arbiter.sv | 46 ++++
 rtl/perf_counter_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_perf_counter_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_seq_pkg.sv
// Shared definitions for the performance-counter sequencer: op codes, FSM
// states, counter-slave address offsets and address helpers.
// Optional build macro: PERF_SEQ_AUTO_SEC0_EN (adds the ST_WR0 state).
package perf_seq_pkg;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

`ifdef PERF_SEQ_AUTO_SEC0_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_ACK  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_ACK  = 3'd4
  } state_e;
`endif

  localparam logic [1:0] OFF_STOP_LO = 2'd0;
  localparam logic [1:0] OFF_GO_HI   = 2'd1;
  localparam logic [1:0] OFF_EVENT   = 2'd2;
  localparam int unsigned SEC_STRIDE = 4;

  function automatic logic [3:0] sec_addr(input logic [1:0] sec, input logic [1:0] off);
    return 4'(32'(sec) * SEC_STRIDE + 32'(off));
  endfunction

  // CLEAR_ALL always targets the global control word at address 0.
  function automatic logic [3:0] wr_addr(input logic [1:0] op, input logic [1:0] sec);
    logic [3:0] a;
    case (op)
      OP_CLEAR: a = 4'd0;
      OP_START: a = sec_addr(sec, OFF_GO_HI);
      default:  a = sec_addr(sec, OFF_STOP_LO);
    endcase
    return a;
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0] op);
    return (op == OP_CLEAR) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/perf_seq_rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first pending request at
// or after the pointer (wrapping); pointer moves to grant+1 when advanced.
module perf_seq_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic               any_o,
  output logic [PW-1:0]      grant_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   k;

  // Scan requesters starting at the pointer; first hit wins.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(ptr_q) + i) % NUM_REQ;
      if (!any_o && req_i[k]) begin
        any_o   = 1'b1;
        grant_o = PW'(k);
      end
    end
  end

  // Next pointer is the requester after the current grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && any_o) begin
      ptr_d = (32'(grant_o) == NUM_REQ - 1) ? '0 : grant_o + PW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/perf_counter_sequencer.sv
// Hardware master for the 3-section performance-counter slave. Arbitrates
// requesters, issues write strobes or a tear-free 64-bit read sequence,
// and acknowledges the granted requester.
// Optional build macro: PERF_SEQ_AUTO_SEC0_EN -- a START of section s>0
// while section 0 is stopped first starts section 0 (extra ST_WR0 cycle).
module perf_counter_sequencer
  import perf_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned NUM_SEC = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [2*NUM_REQ-1:0] req_sec,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [63:0]          rsp_data,
  output logic                 rsp_err,
  output logic [3:0]           pc_address,
  output logic                 pc_write,
  output logic                 pc_begintransfer,
  output logic [31:0]          pc_writedata,
  input  logic [31:0]          pc_readdata
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         sec_q, sec_d;
  logic [2:0]         step_q, step_d;
  logic [31:0]        hi1_q, hi1_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi2_q, hi2_d;
  logic               sec0_run_q, sec0_run_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [63:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [3:0]         addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic               arb_any, arb_adv;
  logic [GW-1:0]      arb_grant;
  logic [1:0]         in_op, in_sec;
  logic [NUM_REQ-1:0] arb_onehot, gnt_onehot;

  perf_seq_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (GW)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req_valid),
    .advance_i (arb_adv),
    .any_o     (arb_any),
    .grant_o   (arb_grant)
  );

  // Select the granted requester's op/section and build one-hot grant masks.
  always_comb begin
    in_op      = '0;
    in_sec     = '0;
    arb_onehot = '0;
    gnt_onehot = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (GW'(r) == arb_grant) begin
        in_op         = req_op[2*r +: 2];
        in_sec        = req_sec[2*r +: 2];
        arb_onehot[r] = 1'b1;
      end
      if (GW'(r) == gnt_q) gnt_onehot[r] = 1'b1;
    end
  end

  // Sequencer FSM; bus outputs are registered, so each state computes the
  // bus value for the following cycle. Readdata lags address by one cycle.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    sec_d      = sec_q;
    step_d     = step_q;
    hi1_d      = hi1_q;
    lo_d       = lo_q;
    hi2_d      = hi2_q;
    sec0_run_d = sec0_run_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ack_d      = '0;
    addr_d     = '0;
    wr_d       = 1'b0;
    wdata_d    = '0;
    arb_adv    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          arb_adv = 1'b1;
          gnt_d   = arb_grant;
          op_d    = in_op;
          sec_d   = in_sec;
          // CLEAR_ALL ignores the section, so it is exempt from the range check.
          if (in_op != OP_CLEAR && 32'(in_sec) >= NUM_SEC) begin
            state_d   = ST_ACK;
            ack_d     = arb_onehot;
            rsp_err_d = 1'b1;
          end else if (in_op == OP_READ) begin
            state_d = ST_RD;
            step_d  = 3'd1;
            addr_d  = sec_addr(in_sec, OFF_GO_HI);
          end else begin
            state_d = ST_WR;
            addr_d  = wr_addr(in_op, in_sec);
            wdata_d = wr_data(in_op);
            wr_d    = 1'b1;
`ifdef PERF_SEQ_AUTO_SEC0_EN
            if (in_op == OP_START && in_sec != 2'd0 && !sec0_run_q) begin
              state_d = ST_WR0;
              addr_d  = sec_addr(2'd0, OFF_GO_HI);
              wdata_d = '0;
            end
`endif
          end
        end
      end

`ifdef PERF_SEQ_AUTO_SEC0_EN
      ST_WR0: begin
        sec0_run_d = 1'b1;
        state_d    = ST_WR;
        addr_d     = wr_addr(op_q, sec_q);
        wdata_d    = wr_data(op_q);
        wr_d       = 1'b1;
      end
`endif

      ST_WR: begin
        if (op_q == OP_START && sec_q == 2'd0) begin
          sec0_run_d = 1'b1;
        end else if (op_q == OP_CLEAR || (op_q == OP_STOP && sec_q == 2'd0)) begin
          sec0_run_d = 1'b0;
        end
        state_d   = ST_ACK;
        ack_d     = gnt_onehot;
        rsp_err_d = 1'b0;
      end

      ST_RD: begin
        case (step_q)
          3'd1: begin
            addr_d = sec_addr(sec_q, OFF_STOP_LO);
            step_d = 3'd2;
          end
          3'd2: begin
            hi1_d  = pc_readdata;
            addr_d = sec_addr(sec_q, OFF_GO_HI);
            step_d = 3'd3;
          end
          3'd3: begin
            lo_d   = pc_readdata;
            step_d = 3'd4;
          end
          3'd4: begin
            // A changed high word means LO may belong to either epoch; reread LO once.
            if (pc_readdata == hi1_q) begin
              rsp_data_d = {hi1_q, lo_q};
              rsp_err_d  = 1'b0;
              ack_d      = gnt_onehot;
              state_d    = ST_ACK;
              step_d     = 3'd0;
            end else begin
              hi2_d  = pc_readdata;
              addr_d = sec_addr(sec_q, OFF_STOP_LO);
              step_d = 3'd5;
            end
          end
          3'd5: begin
            step_d = 3'd6;
          end
          3'd6: begin
            rsp_data_d = {hi2_q, pc_readdata};
            rsp_err_d  = 1'b0;
            ack_d      = gnt_onehot;
            state_d    = ST_ACK;
            step_d     = 3'd0;
          end
          default: begin
            state_d = ST_IDLE;
            step_d  = 3'd0;
          end
        endcase
      end

      ST_ACK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      op_q       <= '0;
      sec_q      <= '0;
      step_q     <= '0;
      hi1_q      <= '0;
      lo_q       <= '0;
      hi2_q      <= '0;
      sec0_run_q <= 1'b0;
      ack_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      addr_q     <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      sec_q      <= sec_d;
      step_q     <= step_d;
      hi1_q      <= hi1_d;
      lo_q       <= lo_d;
      hi2_q      <= hi2_d;
      sec0_run_q <= sec0_run_d;
      ack_q      <= ack_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign req_ack          = ack_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;
  assign pc_address       = addr_q;
  assign pc_write         = wr_q;
  assign pc_begintransfer = wr_q;
  assign pc_writedata     = wdata_q;

endmodule

// File: tb/tb_perf_counter_sequencer.sv
// Scoreboard bench for perf_counter_sequencer: directed requests push the
// expected writes and acks; a monitor pops and compares as the DUT emits them.
module tb_perf_counter_sequencer;
  import perf_seq_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int NUM_SEC = 3;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [2*NUM_REQ-1:0] req_op = '0;
  logic [2*NUM_REQ-1:0] req_sec = '0;
  logic [NUM_REQ-1:0]   req_ack;
  logic [63:0]          rsp_data;
  logic                 rsp_err;
  logic [3:0]           pc_address;
  logic                 pc_write;
  logic                 pc_begintransfer;
  logic [31:0]          pc_writedata;
  logic [31:0]          pc_readdata;

  perf_counter_sequencer #(
    .NUM_REQ (NUM_REQ),
    .NUM_SEC (NUM_SEC)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_op           (req_op),
    .req_sec          (req_sec),
    .req_ack          (req_ack),
    .rsp_data         (rsp_data),
    .rsp_err          (rsp_err),
    .pc_address       (pc_address),
    .pc_write         (pc_write),
    .pc_begintransfer (pc_begintransfer),
    .pc_writedata     (pc_writedata),
    .pc_readdata      (pc_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counter slave model: one free 64-bit timer, registered readdata.
  logic [63:0] cnt;
  logic        cnt_load = 1'b0;
  logic [63:0] cnt_val = '0;
  logic        cnt_inc = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      pc_readdata <= '0;
    end else begin
      if (cnt_load)     cnt <= cnt_val;
      else if (cnt_inc) cnt <= cnt + 64'd1;
      case (pc_address[1:0])
        2'd0:    pc_readdata <= cnt[31:0];
        2'd1:    pc_readdata <= cnt[63:32];
        default: pc_readdata <= '0;
      endcase
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    bit          err;
    logic [63:0] data;
    int          at;
  } ack_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  ack_t ack_q[$];
  wr_t  wr_q[$];

  int          c0 = 0;
  logic [63:0] exp_rd = '0;
  logic [3:0]  alog [0:15];

  task automatic raise(input int idx, input logic [1:0] op, input logic [1:0] sec);
    req_op[2*idx +: 2]  = op;
    req_sec[2*idx +: 2] = sec;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic exp_ack(input int idx, input bit err, input int lat);
    ack_t e;
    e.idx  = idx;
    e.err  = err;
    e.data = exp_rd;
    e.at   = (lat < 0) ? -1 : c0 + lat;
    ack_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [3:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endtask

  // Hold requests until acked, log the bus address per cycle, then step
  // one more cycle so the next request is raised while the FSM is idle.
  task automatic wait_acks(input logic [NUM_REQ-1:0] mask_in);
    logic [NUM_REQ-1:0] mask;
    int n;
    mask = mask_in;
    n = 0;
    while (mask != '0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (cyc - c0 >= 0 && cyc - c0 < 16) alog[cyc - c0] = pc_address;
      cnt_load = 1'b0;
      mask      = mask & ~req_ack;
      req_valid = req_valid & ~req_ack;
    end
    if (mask != '0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: pending mask 0x%0h, expected 0x0", mask);
      req_valid = '0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every bus write and every ack against the queues.
  ack_t               m_ack;
  wr_t                m_wr;
  logic [NUM_REQ-1:0] m_oh;
  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (pc_write || pc_begintransfer) begin
        chk("begintransfer_eq_write", {63'b0, pc_begintransfer}, {63'b0, pc_write});
        if (wr_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", pc_address, pc_writedata);
        end else begin
          m_wr = wr_q.pop_front();
          chk("write_addr", {60'b0, pc_address}, {60'b0, m_wr.addr});
          chk("write_data", {32'b0, pc_writedata}, {32'b0, m_wr.data});
        end
      end
      if (req_ack != '0) begin
        if (ack_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_ack: got req_ack 0x%0h, expected none", req_ack);
        end else begin
          m_ack = ack_q.pop_front();
          m_oh = '0;
          m_oh[m_ack.idx] = 1'b1;
          chk("ack_onehot", {60'b0, req_ack}, {60'b0, m_oh});
          chk("rsp_err", {63'b0, rsp_err}, {63'b0, m_ack.err});
          chk("rsp_data", rsp_data, m_ack.data);
          if (m_ack.at >= 0) chk("ack_cycle", 64'(cyc), 64'(m_ack.at));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ack"}, {60'b0, req_ack}, '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_err"}, {63'b0, rsp_err}, '0);
    chk({tag, "_pc_address"}, {60'b0, pc_address}, '0);
    chk({tag, "_pc_write"}, {63'b0, pc_write}, '0);
    chk({tag, "_pc_begintransfer"}, {63'b0, pc_begintransfer}, '0);
    chk({tag, "_pc_writedata"}, {32'b0, pc_writedata}, '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_sec0_run", {63'b0, dut.sec0_run_q}, '0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // START section 1 with section 0 stopped.
    c0 = cyc;
    raise(0, OP_START, 2'd1);
`ifdef PERF_SEQ_AUTO_SEC0_EN
    exp_wr(4'd1, 32'd0);
    exp_wr(4'd5, 32'd0);
    exp_ack(0, 1'b0, 3);
    wait_acks(4'b0001);
    chk("sec0_run_after_start1", {63'b0, dut.sec0_run_q}, 64'd1);
`else
    exp_wr(4'd5, 32'd0);
    exp_ack(0, 1'b0, 2);
    wait_acks(4'b0001);
    chk("sec0_run_after_start1", {63'b0, dut.sec0_run_q}, 64'd0);
`endif

    // READ_TIME section 0, stable counter.
    cnt_load = 1'b1;
    cnt_val  = 64'h0000_0000_0000_1234;
    cnt_inc  = 1'b0;
    c0 = cyc;
    raise(1, OP_READ, 2'd0);
    exp_rd = 64'h0000_0000_0000_1234;
    exp_ack(1, 1'b0, 5);
    wait_acks(4'b0010);
    chk("rd_addr_t1", {60'b0, alog[1]}, 64'd1);
    chk("rd_addr_t2", {60'b0, alog[2]}, 64'd0);
    chk("rd_addr_t3", {60'b0, alog[3]}, 64'd1);

    // STOP section 1; rsp_data must hold the last read value.
    c0 = cyc;
    raise(3, OP_STOP, 2'd1);
    exp_wr(4'd4, 32'd0);
    exp_ack(3, 1'b0, 2);
    wait_acks(4'b1000);

    // READ_TIME across a low-word carry: forces the retry path.
    cnt_load = 1'b1;
    cnt_val  = 64'h0000_0000_FFFF_FFFE;
    cnt_inc  = 1'b1;
    c0 = cyc;
    raise(1, OP_READ, 2'd0);
    exp_rd = 64'h0000_0001_0000_0002;
    exp_ack(1, 1'b0, 7);
    wait_acks(4'b0010);
    cnt_inc = 1'b0;
    chk("retry_addr_t1", {60'b0, alog[1]}, 64'd1);
    chk("retry_addr_t2", {60'b0, alog[2]}, 64'd0);
    chk("retry_addr_t3", {60'b0, alog[3]}, 64'd1);

    // START section 0.
    c0 = cyc;
    raise(3, OP_START, 2'd0);
    exp_wr(4'd1, 32'd0);
    exp_ack(3, 1'b0, 2);
    wait_acks(4'b1000);
    chk("sec0_run_after_start0", {63'b0, dut.sec0_run_q}, 64'd1);

    // All four requesters STOP section 0 at once: round-robin 0,1,2,3.
    c0 = cyc;
    for (int i = 0; i < NUM_REQ; i++) begin
      raise(i, OP_STOP, 2'd0);
      exp_wr(4'd0, 32'd0);
      exp_ack(i, 1'b0, 2 + 3 * i);
    end
    wait_acks(4'b1111);
    chk("sec0_run_after_stop0", {63'b0, dut.sec0_run_q}, 64'd0);

    // Re-raise requesters 0 and 2: 0 then 2.
    c0 = cyc;
    raise(0, OP_STOP, 2'd2);
    raise(2, OP_STOP, 2'd2);
    exp_wr(4'd8, 32'd0);
    exp_wr(4'd8, 32'd0);
    exp_ack(0, 1'b0, 2);
    exp_ack(2, 1'b0, 5);
    wait_acks(4'b0101);

    // START of an unimplemented section: error ack, no bus write.
    c0 = cyc;
    raise(2, OP_START, 2'd3);
    exp_ack(2, 1'b1, -1);
    wait_acks(4'b0100);

    // Next good ack clears rsp_err; section 0 running again.
    c0 = cyc;
    raise(3, OP_START, 2'd0);
    exp_wr(4'd1, 32'd0);
    exp_ack(3, 1'b0, 2);
    wait_acks(4'b1000);
    chk("sec0_run_before_clear", {63'b0, dut.sec0_run_q}, 64'd1);

    // CLEAR_ALL with an out-of-range section: still a normal write.
    c0 = cyc;
    raise(1, OP_CLEAR, 2'd3);
    exp_wr(4'd0, 32'd1);
    exp_ack(1, 1'b0, 2);
    wait_acks(4'b0010);
    chk("sec0_run_after_clear", {63'b0, dut.sec0_run_q}, 64'd0);

    // Reset during read step t3: outputs clear at once, no ack afterwards.
    c0 = cyc;
    raise(1, OP_READ, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;

    chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
    chk("write_queue_drained", 64'(wr_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
